// File: rtl/comp_pkg.sv
// ---------------------------------------------------------------------------
// comp_pkg
// Shared definitions for the comparison-unit family of blocks.
//   - comp_search_state_t : states of the binary-search initiator
//   - COMP_WIDTH          : default operand width of the comparator datapath
// ---------------------------------------------------------------------------
package comp_pkg;

  localparam int COMP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    EVAL  = 2'd2,
    FIN   = 2'd3
  } comp_search_state_t;

endpackage : comp_pkg

// File: rtl/comp_mid.sv
// ---------------------------------------------------------------------------
// comp_mid
// Combinational midpoint and bound-compare helper for the search controller.
// Works in unsigned or two's-complement mode.
// Ports:
//   i_lo, i_hi  : interval bounds (WIDTH bits)
//   i_isSigned  : 1 = interpret bounds as two's complement
//   o_mid       : floor((lo + hi) / 2) in the selected interpretation
//   o_loGtHi    : 1 when lo > hi in the selected interpretation (empty interval)
// ---------------------------------------------------------------------------
module comp_mid
  import comp_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH
) (
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic             i_isSigned,
  output logic [WIDTH-1:0] o_mid,
  output logic             o_loGtHi
);

  logic [WIDTH:0]   w_extLo;
  logic [WIDTH:0]   w_extHi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_biasLo;
  logic [WIDTH-1:0] w_biasHi;

  // Extend both bounds by one bit (sign or zero) so the sum can never
  // overflow. Halving keeps the low WIDTH bits of sum>>1; the extension bit
  // only matters for the dropped MSB, so a logical shift is sufficient here.
  assign w_extLo = {i_isSigned & i_lo[WIDTH-1], i_lo};
  assign w_extHi = {i_isSigned & i_hi[WIDTH-1], i_hi};
  assign w_sum   = w_extLo + w_extHi;
  assign o_mid   = WIDTH'(w_sum >> 1);

  // A signed compare is an unsigned compare with the sign bits flipped,
  // which lets one comparator serve both modes.
  assign w_biasLo = {i_lo[WIDTH-1] ^ i_isSigned, i_lo[WIDTH-2:0]};
  assign w_biasHi = {i_hi[WIDTH-1] ^ i_isSigned, i_hi[WIDTH-2:0]};
  assign o_loGtHi = (w_biasLo > w_biasHi);

endmodule : comp_mid

// File: rtl/comp_search_ctrl.sv
// ---------------------------------------------------------------------------
// comp_search_ctrl
// Binary-search initiator that drives probe values into the comparison
// unit's in0 port and narrows [lo, hi] from the GT/LT/ET flags until the
// target is hit or the interval is exhausted.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a search (sampled only in IDLE)
//   lo_in, hi_in        : inclusive bounds, captured on accepted start
//   is_signed           : two's-complement mode, captured on accepted start
//   GT, LT, ET          : comparator flags for the registered probe
//   probe, is_signed_o  : registered operand and mode to the comparator
//   busy, done          : search in progress / one-cycle completion pulse
//   found, result, err  : outcome, held until the next accepted start
//   probe_cnt           : probes issued (only with COMP_SEARCH_STATS_EN)
// Configuration macro: COMP_SEARCH_STATS_EN adds the probe_cnt counter/port.
// ---------------------------------------------------------------------------
module comp_search_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WIDTH-1:0]            lo_in,
  input  logic [WIDTH-1:0]            hi_in,
  input  logic                        is_signed,
  input  logic                        GT,
  input  logic                        LT,
  input  logic                        ET,
  output logic [WIDTH-1:0]            probe,
  output logic                        is_signed_o,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [WIDTH-1:0]            result,
`ifdef COMP_SEARCH_STATS_EN
  output logic [$clog2(WIDTH+2)-1:0]  probe_cnt,
`endif
  output logic                        err
);

  comp_search_state_t r_state;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_signed;
  logic [WIDTH-1:0]   r_probe;
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic [WIDTH-1:0]   r_result;
  logic               r_err;
  logic [WIDTH-1:0]   w_mid;
  logic               w_loGtHi;
  logic [2:0]         w_flags;

  // Midpoint of the current interval and the empty-interval test share one
  // helper so both honour the captured signedness identically.
  comp_mid #(.WIDTH(WIDTH)) u_mid (
    .i_lo      (r_lo),
    .i_hi      (r_hi),
    .i_isSigned(r_signed),
    .o_mid     (w_mid),
    .o_loGtHi  (w_loGtHi)
  );

  assign w_flags = {GT, LT, ET};

`ifdef COMP_SEARCH_STATS_EN
  localparam int CNT_W = $clog2(WIDTH+2);
  logic [CNT_W-1:0] r_cnt;

  // Probe counter: cleared when a search is accepted, bumped whenever a new
  // probe is registered, and left alone afterwards so it can be read later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && start && !r_done) begin
      r_cnt <= '0;
    end else if (r_state == PROBE && !w_loGtHi) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign probe_cnt = r_cnt;
`endif

  // Search sequencer. Every output is a register so the comparator sees a
  // stable probe for the whole EVAL cycle. A start arriving while done is
  // still high is dropped, so back-to-back searches need one idle cycle.
  // The exhaustion checks in EVAL stop before lo/hi could step past the
  // interval ends, which is why the bound updates never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_signed <= 1'b0;
      r_probe  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start && !r_done) begin
            r_lo     <= lo_in;
            r_hi     <= hi_in;
            r_signed <= is_signed;
            r_busy   <= 1'b1;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_state  <= PROBE;
          end
        end
        PROBE: begin
          if (w_loGtHi) begin
            r_found <= 1'b0;
            r_state <= FIN;
          end else begin
            r_probe <= w_mid;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_result <= r_probe;
          case (w_flags)
            3'b001: begin
              r_found <= 1'b1;
              r_state <= FIN;
            end
            3'b010: begin
              if (r_probe == r_hi) begin
                r_state <= FIN;
              end else begin
                r_lo    <= r_probe + WIDTH'(1);
                r_state <= PROBE;
              end
            end
            3'b100: begin
              if (r_probe == r_lo) begin
                r_state <= FIN;
              end else begin
                r_hi    <= r_probe - WIDTH'(1);
                r_state <= PROBE;
              end
            end
            default: begin
              r_err   <= 1'b1;
              r_found <= 1'b0;
              r_state <= FIN;
            end
          endcase
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign probe       = r_probe;
  assign is_signed_o = r_signed;
  assign busy        = r_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign result      = r_result;
  assign err         = r_err;

endmodule : comp_search_ctrl

// File: tb/tb_comp_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comp_search_ctrl
// Self-checking bench for comp_search_ctrl. A behavioural comparator drives
// the flags from the DUT probe and a bench-held target; an integer-arithmetic
// binary-search model predicts probe count, outcome and latency.
// ---------------------------------------------------------------------------
module tb_comp_search_ctrl;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  lo_in;
  logic [W-1:0]  hi_in;
  logic          is_signed;
  logic          GT, LT, ET;
  logic [W-1:0]  probe;
  logic          is_signed_o;
  logic          busy;
  logic          done;
  logic          found;
  logic [W-1:0]  result;
  logic          err;
`ifdef COMP_SEARCH_STATS_EN
  logic [4:0]    probe_cnt;
`endif

  logic [W-1:0]  target;
  logic          forceBoth;
  logic          gtM, ltM, etM;
  int            testCount;
  int            failCount;

  comp_search_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lo_in      (lo_in),
    .hi_in      (hi_in),
    .is_signed  (is_signed),
    .GT         (GT),
    .LT         (LT),
    .ET         (ET),
    .probe      (probe),
    .is_signed_o(is_signed_o),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .result     (result),
`ifdef COMP_SEARCH_STATS_EN
    .probe_cnt  (probe_cnt),
`endif
    .err        (err)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the comparison unit: in1 is the bench target,
  // and forceBoth injects the illegal GT+LT combination
  always_comb begin
    if (is_signed_o) begin
      gtM = $signed(probe) > $signed(target);
      ltM = $signed(probe) < $signed(target);
    end else begin
      gtM = probe > target;
      ltM = probe < target;
    end
    etM = (probe == target);
  end

  assign GT = gtM | forceBoth;
  assign LT = ltM | forceBoth;
  assign ET = etM;

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference search on plain integers: number of probes, outcome, the
  // last probe value and the first probe value
  function automatic void refSearch(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                    input logic [W-1:0] tgt, input bit sgn,
                                    output int n, output bit fnd,
                                    output logic [W-1:0] res, output logic [W-1:0] first);
    int l, h, t, m;
    l = sgn ? int'($signed(lo))  : int'(lo);
    h = sgn ? int'($signed(hi))  : int'(hi);
    t = sgn ? int'($signed(tgt)) : int'(tgt);
    n = 0; fnd = 0; res = '0; first = '0;
    while (l <= h) begin
      m = (l + h) >>> 1;
      n++;
      if (n == 1) first = W'(m);
      res = W'(m);
      if (m == t) begin
        fnd = 1;
        break;
      end else if (m < t) begin
        l = m + 1;
      end else begin
        h = m - 1;
      end
    end
  endfunction

  // Run one search end to end and check every observable against the model
  task automatic applyStimulus(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                               input bit sgn, input logic [W-1:0] tgt, input bit fault);
    int n, k, expLat;
    bit fnd, gotDone;
    logic [W-1:0] res, first, prevProbe;
    refSearch(lo, hi, tgt, sgn, n, fnd, res, first);
    if (fault && n > 0) begin
      n = 1; fnd = 0; res = first;
    end
    expLat = (n > 0) ? 2 * n + 2 : 3;
    @(negedge clk);
    lo_in = lo; hi_in = hi; is_signed = sgn; target = tgt;
    forceBoth = fault; start = 1'b1;
    prevProbe = probe;
    k = 0; gotDone = 0;
    while (k < 100 && !gotDone) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        lo_in = $urandom; hi_in = $urandom; is_signed = $urandom;
        checkOutput({tag, ".busyRise"}, busy, 1);
      end
      if (k == 2 && n > 0) checkOutput({tag, ".firstProbe"}, probe, first);
      if (done) gotDone = 1;
    end
    checkOutput({tag, ".doneSeen"}, gotDone, 1);
    checkOutput({tag, ".latency"}, k, expLat);
    checkOutput({tag, ".found"}, found, fnd);
    checkOutput({tag, ".err"}, err, fault && n > 0);
    checkOutput({tag, ".busyLow"}, busy, 0);
    if (fnd || n > 0) checkOutput({tag, ".result"}, result, res);
    if (n == 0) checkOutput({tag, ".noProbe"}, probe, prevProbe);
`ifdef COMP_SEARCH_STATS_EN
    checkOutput({tag, ".probeCnt"}, probe_cnt, n);
`endif
    // A start raised during the done cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    forceBoth = 1'b0;
    checkOutput({tag, ".donePulse"}, done, 0);
    checkOutput({tag, ".startIgnored"}, busy, 0);
    checkOutput({tag, ".foundHold"}, found, fnd);
  endtask

  initial begin
    int l, h, t;
    bit sgn;
    logic [W-1:0] lo, hi, tgt;
    testCount = 0; failCount = 0;
    rst_n = 1'b0; start = 1'b0; lo_in = '0; hi_in = '0; is_signed = 1'b0;
    target = '0; forceBoth = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.probe", probe, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.found", found, 0);
    checkOutput("reset.err", err, 0);
    rst_n = 1'b1;

    // Directed scenarios
    applyStimulus("unsigned",  16'h0000, 16'hFFFF, 0, 16'd12345, 0);
    applyStimulus("signed",    16'h8000, 16'h7FFF, 1, 16'hFFF6, 0);
    applyStimulus("empty",     16'd10,   16'd5,    0, 16'd7,    0);
    applyStimulus("upperHit",  16'hFFFE, 16'hFFFF, 0, 16'hFFFF, 0);
    applyStimulus("upperMiss", 16'hFFFE, 16'hFFFF, 0, 16'h0000, 0);
    applyStimulus("lowerMiss", 16'h0000, 16'h0001, 0, 16'hFFFF, 0);
    applyStimulus("flagFault", 16'h0000, 16'hFFFF, 0, 16'd100,  1);

    // Reset during the first EVAL aborts the search with no done
    @(negedge clk);
    lo_in = 16'h8000; hi_in = 16'h7FFF; is_signed = 1'b1; target = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.probe", probe, 0);
    checkOutput("abort.signed", is_signed_o, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.found", found, 0);
    checkOutput("abort.result", result, 0);
    checkOutput("abort.err", err, 0);
`ifdef COMP_SEARCH_STATS_EN
    checkOutput("abort.probeCnt", probe_cnt, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort.noDone", done, 0);
    end
    rst_n = 1'b1;
    applyStimulus("afterAbort", 16'd100, 16'd200, 0, 16'd150, 0);

    // Randomised searches, mixing in-range targets, misses and empty ranges
    for (int r = 0; r < 30; r++) begin
      sgn = $urandom_range(0, 1);
      lo  = $urandom;
      if ($urandom_range(0, 2) == 0) hi = lo + W'($urandom_range(0, 20));
      else hi = $urandom;
      l = sgn ? int'($signed(lo)) : int'(lo);
      h = sgn ? int'($signed(hi)) : int'(hi);
      if (l <= h && $urandom_range(0, 3) != 0) begin
        t = l + int'($urandom_range(0, h - l));
        tgt = W'(t);
      end else begin
        tgt = $urandom;
      end
      applyStimulus("random", lo, hi, sgn, tgt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule : tb_comp_search_ctrl
